// File: rtl/dmem_wbuf_if.sv
// dmem_wbuf_if: load/store port of the data memory. The memory stage drives it as master
// and the memory is the slave.
interface dmem_wbuf_if;
    logic [31:0] a;
    logic [31:0] wd;
    logic        we;
    logic [31:0] rd;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    modport master (output a, wd, we, input rd, count, full, empty);
    modport slave  (input a, wd, we, output rd, count, full, empty);
endinterface

// File: rtl/dmem_wbuf.sv
// dmem_wbuf: 64x32 data RAM. Defining DMEM_WBUF_EN adds a DEPTH-entry store FIFO with load forwarding.
// The default build, with DMEM_WBUF_EN undefined, writes stores straight into the RAM.
module dmem_wbuf #(
    parameter int DEPTH = 4
) (
    input logic        clk,
    input logic        reset,
    dmem_wbuf_if.slave bus
);
    logic [5:0]  wordIdx;
    logic [25:0] unusedAddrBits;
    logic [31:0] mem [64];
    logic        ramWe;
    logic [5:0]  ramAdr;
    logic [31:0] ramDat;

    assign wordIdx        = bus.a[7:2];
    assign unusedAddrBits = {bus.a[31:8], bus.a[1:0]};

    // NOTE: RAM contents carry no reset; clearing 64 words is neither needed nor wanted.
    always_ff @(posedge clk) begin
        if (ramWe) mem[ramAdr] <= ramDat;
    end

`ifdef DMEM_WBUF_EN
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic [CW-1:0]    cnt;
    logic [DEPTH-1:0] vld;
    logic [5:0]       adrQ [DEPTH];
    logic [31:0]      datQ [DEPTH];
    logic             isFull;
    logic             isEmpty;
    logic             drain;
    logic             fwdHit;
    logic [31:0]      fwdDat;
    logic [PW-1:0]    slot;

    assign isFull  = (cnt == CW'(DEPTH));
    assign isEmpty = (cnt == '0);
    // Drain on an idle cycle, or when a store arrives at a full buffer so nothing is dropped.
    assign drain   = !reset && !isEmpty && (!bus.we || isFull);

    // NOTE: state registers use non-blocking assignments so every read in this block sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
            vld   <= '0;
        end else begin
            if (drain) begin
                vld[rdPtr] <= 1'b0;
                rdPtr      <= rdPtr + 1'b1;
            end
            // Placed after the drain so a full-buffer store re-validates the slot just freed.
            if (bus.we) begin
                vld[wrPtr] <= 1'b1;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (bus.we && !isFull) cnt <= cnt + 1'b1;
            else if (drain)        cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && bus.we) begin
            adrQ[wrPtr] <= wordIdx;
            datQ[wrPtr] <= bus.wd;
        end
    end

    assign ramWe  = drain;
    assign ramAdr = adrQ[rdPtr];
    assign ramDat = datQ[rdPtr];

    // Walk oldest to youngest so the last match found is the youngest store.
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        fwdHit = 1'b0;
        fwdDat = '0;
        slot   = rdPtr;
        for (int k = 0; k < DEPTH; k++) begin
            slot = rdPtr + PW'(k);
            if (vld[slot] && adrQ[slot] == wordIdx) begin
                fwdHit = 1'b1;
                fwdDat = datQ[slot];
            end
        end
    end

    assign bus.rd    = fwdHit ? fwdDat : mem[wordIdx];
    assign bus.count = 3'(cnt);
    assign bus.full  = isFull;
    assign bus.empty = isEmpty;
`else
    localparam int unusedDepth = DEPTH;

    assign ramWe     = bus.we && !reset;
    assign ramAdr    = wordIdx;
    assign ramDat    = bus.wd;
    assign bus.rd    = mem[wordIdx];
    assign bus.count = 3'd0;
    assign bus.full  = 1'b0;
    assign bus.empty = 1'b1;
`endif
endmodule

// File: tb/tb_dmem_wbuf.sv
// tb_dmem_wbuf: directed and random stimulus for dmem_wbuf checked against a queue-based model.
// The expected behaviour follows DMEM_WBUF_EN, which must be defined for both bench and design or for neither.
module tb_dmem_wbuf;
`ifdef DMEM_WBUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif
    localparam int MDEPTH = 4;

    typedef struct packed {
        logic [5:0]  adr;
        logic [31:0] dat;
    } store_t;

    logic clk;
    logic reset;
    dmem_wbuf_if bus ();

    dmem_wbuf #(.DEPTH(MDEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit ready  = 1'b0;

    // Model: committed RAM image plus an ordered list of pending stores.
    logic [31:0] mram [64];
    bit          mknown [64];
    store_t      pend [$];
    bit          ramHit;
    logic [5:0]  ramIdx;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit mKnown(logic [5:0] idx);
        foreach (pend[i]) if (pend[i].adr == idx) return 1'b1;
        return mknown[idx];
    endfunction

    function automatic logic [31:0] mRead(logic [5:0] idx);
        for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].adr == idx) return pend[i].dat;
        return mram[idx];
    endfunction

    task automatic commit(logic [5:0] idx, logic [31:0] d);
        mram[idx]   = d;
        mknown[idx] = 1'b1;
        ramHit      = 1'b1;
        ramIdx      = idx;
    endtask

    task automatic modelStep(bit rst, bit w, logic [5:0] idx, logic [31:0] d);
        store_t s;
        ramHit = 1'b0;
        if (rst) begin
            pend.delete();
        end else if (!BUF) begin
            if (w) commit(idx, d);
        end else if (w) begin
            if (pend.size() == MDEPTH) begin
                s = pend.pop_front();
                commit(s.adr, s.dat);
            end
            s.adr = idx;
            s.dat = d;
            pend.push_back(s);
        end else if (pend.size() > 0) begin
            s = pend.pop_front();
            commit(s.adr, s.dat);
        end
    endtask

    bit          curRst;
    bit          curWe;
    logic [31:0] curA;
    logic [31:0] curWd;

    // Drive one cycle's inputs on the falling edge, then compare the outputs against the model.
    task automatic drive(bit w, logic [31:0] adr, logic [31:0] d, bit rst = 1'b0);
        int n;
        @(negedge clk);
        reset  = rst;
        bus.we = w;
        bus.a  = adr;
        bus.wd = d;
        curRst = rst; curWe = w; curA = adr; curWd = d;
        #1;
        if (ready) begin
            n = BUF ? pend.size() : 0;
            if (mKnown(adr[7:2])) check("rd", bus.rd, mRead(adr[7:2]));
            check("count", 32'(bus.count), 32'(n));
            check("full", 32'(bus.full), 32'(n == MDEPTH));
            check("empty", 32'(bus.empty), 32'(n == 0));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep(curRst, curWe, curA[7:2], curWd);
        if (curRst) ready = 1'b1;
        #1;
        if (ramHit) check("ram", dut.mem[ramIdx], mram[ramIdx]);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 32'h0, 32'h0);
            tick();
        end
    endtask

    logic [31:0] old40;
    logic [31:0] old4c;
    logic [31:0] adr;

    initial begin
        foreach (mknown[i]) mknown[i] = 1'b0;
        reset = 1'b1; bus.we = 1'b0; bus.a = '0; bus.wd = '0;
        drive(1'b0, 32'h0, 32'h0, 1'b1); tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1); tick();

        // Give every RAM word a known value.
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 32'(i * 4), $urandom);
            tick();
        end
        idle(5);

        // Single store, then drain.
        drive(1'b1, 32'h10, 32'hA5A5A5A5); tick();
        drive(1'b0, 32'h10, 32'h0);
        check("r25_rd", bus.rd, 32'hA5A5A5A5);
        check("r25_cnt1", 32'(bus.count), BUF ? 32'd1 : 32'd0);
        tick();
        drive(1'b0, 32'h10, 32'h0);
        check("r25_cnt0", 32'(bus.count), 32'd0);
        tick();

        // Six back-to-back stores overflow the buffer into RAM.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'(i * 4), 32'(i + 1));
            tick();
        end
        drive(1'b0, 32'h0, 32'h0);
        check("r26_cnt", 32'(bus.count), BUF ? 32'd4 : 32'd0);
        check("r26_full", 32'(bus.full), 32'(BUF));
        check("r26_ram0", dut.mem[0], 32'd1);
        check("r26_ram4", dut.mem[1], 32'd2);
        tick();
        idle(4);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 32'(i * 4), 32'h0);
            check("r26_rb", bus.rd, 32'(i + 1));
            tick();
        end

        // Youngest of two stores to one address wins.
        drive(1'b1, 32'h20, 32'h11); tick();
        drive(1'b1, 32'h20, 32'h22); tick();
        drive(1'b0, 32'h20, 32'h0);
        check("r27_fwd", bus.rd, 32'h22);
        tick();
        idle(4);
        check("r27_ram", dut.mem[8], 32'h22);

        // Read-before-write in the store cycle.
        drive(1'b1, 32'h30, 32'h9); tick();
        idle(5);
        drive(1'b1, 32'h30, 32'h5);
        check("r28_old", bus.rd, 32'h9);
        tick();
        drive(1'b0, 32'h30, 32'h0);
        check("r28_new", bus.rd, 32'h5);
        tick();
        idle(5);

        // Pending stores are discarded by reset; a store during reset is ignored.
        old40 = mram[16];
        old4c = mram[19];
        drive(1'b1, 32'h40, 32'h1111_0040); tick();
        drive(1'b1, 32'h44, 32'h1111_0044); tick();
        drive(1'b1, 32'h48, 32'h1111_0048); tick();
        drive(1'b1, 32'h4C, 32'hDEAD_BEEF, 1'b1); tick();
        drive(1'b0, 32'h40, 32'h0);
        check("r29_cnt", 32'(bus.count), 32'd0);
        check("r29_empty", 32'(bus.empty), 32'd1);
        check("r29_rd40", bus.rd, BUF ? old40 : 32'h1111_0040);
        tick();
        drive(1'b0, 32'h4C, 32'h0);
        check("r29_rd4c", bus.rd, old4c);
        tick();

        // Random traffic over a few hot words, with an occasional reset.
        for (int i = 0; i < 400; i++) begin
            adr = {$urandom_range(0, 255), 22'h0, 2'b00} | 32'($urandom_range(0, 7) << 2) | 32'($urandom_range(0, 3));
            drive(1'($urandom_range(0, 1)), adr, $urandom, $urandom_range(0, 49) == 0);
            tick();
        end
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_wbuf.md
DMEM_WBUF -- requirements
Module: dmem_wbuf

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 The block SHALL have port a, input, 32 bits: word address from the memory stage ALU result; bits [7:2] select one of 64 RAM words and bits [1:0] are ignored.
REQ-004 The block SHALL have port wd, input, 32 bits: store data from the memory stage.
REQ-005 The block SHALL have port we, input, 1 bit: store request for the current cycle.
REQ-006 The block SHALL have port rd, output, 32 bits: combinational load data for address a.
REQ-007 The block SHALL have port count, output, 3 bits: number of valid store-buffer entries, range 0 to 4.
REQ-008 The block SHALL have port full, output, 1 bit: high when count equals 4.
REQ-009 The block SHALL have port empty, output, 1 bit: high when count equals 0.
REQ-010 The block SHALL have parameter DEPTH, default 4, meaning store-buffer entries, power of two, minimum 2.

Function
REQ-011 The RAM SHALL be 64 x 32, with one write port clocked on the rising edge of clk and one combinational read port.
REQ-012 The store buffer SHALL be a FIFO with DEPTH entries; each entry holds word-address [7:2], data [31:0] and a valid bit; pointers SHALL wrap modulo DEPTH.
REQ-013 When we=1 and the buffer is not full, the block SHALL enqueue {a[7:2], wd} at the clock edge and SHALL NOT drain in that cycle.
REQ-014 When we=1 and the buffer is full, the block SHALL write the oldest entry to RAM and enqueue the new store at the same edge; count SHALL stay at DEPTH; no store is ever dropped.
REQ-015 When we=0 and the buffer is not empty, the block SHALL write the oldest entry to RAM at the edge and decrement count.
REQ-016 When we=0 and the buffer is empty, the block SHALL leave all state unchanged.
REQ-017 rd SHALL equal the data of the youngest valid buffer entry whose address equals a[7:2]; with no match, rd SHALL equal RAM[a[7:2]].
REQ-018 A store presented in the current cycle SHALL NOT affect rd in that same cycle (read-before-write); it SHALL be visible from the next cycle.
REQ-019 An entry being drained in the current cycle SHALL still forward in that cycle; rd SHALL be identical before and after the drain edge.
REQ-020 Load latency SHALL be 0 cycles (combinational) and store visibility latency SHALL be 1 cycle, regardless of buffer occupancy.

Reset
REQ-021 While reset=1 at an edge, the block SHALL set count to 0 and clear all valid bits and both pointers, giving empty=1 and full=0 from the following cycle.
REQ-022 Reset SHALL NOT modify RAM contents; stores still pending in the buffer at reset SHALL be discarded; any we=1 store in the reset cycle SHALL be ignored.

Configuration
REQ-023 With macro DMEM_WBUF_EN defined, the block SHALL implement the store buffer and forwarding per REQ-012 to REQ-020.
REQ-024 Without DMEM_WBUF_EN, the block SHALL write wd to RAM[a[7:2]] at each edge with we=1, and rd SHALL read RAM directly; count SHALL be tied to 0, empty to 1 and full to 0.

Verification
REQ-025 The bench SHALL reset, then store 0xA5A5A5A5 to address 0x10 with we=1 for one cycle, then hold we=0; required: count=1 after the edge, rd at a=0x10 reads 0xA5A5A5A5 next cycle, and count=0 one cycle later.
REQ-026 The bench SHALL issue 6 back-to-back stores of values 1 through 6 to addresses 0x00 through 0x14; required: count saturates at 4 with full=1, RAM[0x00] and RAM[0x04] are written during the stores, and all 6 values read back correctly after draining.
REQ-027 The bench SHALL store 0x11 and then 0x22 to address 0x20 back-to-back; required: rd at a=0x20 reads 0x22 (youngest entry wins), and RAM[0x20] holds 0x22 after the drain.
REQ-028 The bench SHALL drive we=1, wd=0x5, a=0x30 while RAM[0x30] holds 0x9; required: rd reads 0x9 in that cycle and 0x5 in the next.
REQ-029 The bench SHALL enqueue 3 stores and assert reset for one cycle; required: count=0 and empty=1 afterwards, RAM unchanged for the discarded addresses, and a store made during reset is absent.
REQ-030 The bench SHALL rerun REQ-025 and REQ-028 without DMEM_WBUF_EN; required: the written data is readable in the next cycle, and count stays at 0 throughout.
